// File: rtl/fifo_uart_tx.sv
// Read-side FIFO consumer: pops one word per frame and serialises it as a UART
// frame (start, data LSB first, optional parity, one stop) at a runtime bit period.
module fifo_uart_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      FIFO_EMPTY,
    input  logic [DATA_WIDTH-1:0]     FIFO_RD_DATA,
    output logic                      FIFO_RD_INC,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    output logic                      TX_OUT,
    output logic                      BUSY
);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                    state, state_next;
    logic [PRESCALE_WIDTH-1:0] bit_cnt, bit_cnt_next;
    logic [PRESCALE_WIDTH-1:0] period_lat, period_next;
    logic [IDX_W-1:0]          bit_idx, bit_idx_next;
    logic [DATA_WIDTH-1:0]     shift_reg, shift_next;
    logic                      par_en_lat, par_en_next;
    logic                      par_bit_lat, par_bit_next;
    logic                      load, bit_end, last_data;
    logic                      tx_next, busy_next;

    assign bit_end   = (bit_cnt == period_lat - PRESCALE_WIDTH'(1));
    assign last_data = (bit_idx == IDX_W'(DATA_WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            period_lat  <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            par_en_lat  <= 1'b0;
            par_bit_lat <= 1'b0;
            TX_OUT      <= 1'b1;
            BUSY        <= 1'b0;
            FIFO_RD_INC <= 1'b0;
        end else begin
            state       <= state_next;
            bit_cnt     <= bit_cnt_next;
            period_lat  <= period_next;
            bit_idx     <= bit_idx_next;
            shift_reg   <= shift_next;
            par_en_lat  <= par_en_next;
            par_bit_lat <= par_bit_next;
            TX_OUT      <= tx_next;
            BUSY        <= busy_next;
            FIFO_RD_INC <= load;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next   = state;
        load         = 1'b0;
        bit_idx_next = bit_idx;
        shift_next   = shift_reg;
        period_next  = period_lat;
        par_en_next  = par_en_lat;
        par_bit_next = par_bit_lat;
        bit_cnt_next = (state == IDLE || bit_end) ? '0 : bit_cnt + PRESCALE_WIDTH'(1);

        case (state)
            IDLE:    if (!FIFO_EMPTY) begin
                         load       = 1'b1;
                         state_next = START;
                     end
            START:   if (bit_end) state_next = DATA;
            DATA:    if (bit_end && last_data) state_next = par_en_lat ? PARITY : STOP;
            PARITY:  if (bit_end) state_next = STOP;
            STOP:    if (bit_end) begin
                         // Chain straight into the next frame when a word is already waiting.
                         if (!FIFO_EMPTY) begin
                             load       = 1'b1;
                             state_next = START;
                         end else begin
                             state_next = IDLE;
                         end
                     end
            default: state_next = IDLE;
        endcase

        if (state == DATA && bit_end) begin
            shift_next   = shift_reg >> 1;
            bit_idx_next = last_data ? '0 : bit_idx + IDX_W'(1);
        end

        if (load) begin
            shift_next   = FIFO_RD_DATA;
            bit_idx_next = '0;
            period_next  = (PRESCALE == '0) ? PRESCALE_WIDTH'(1) : PRESCALE;
            par_en_next  = PAR_EN;
            par_bit_next = (^FIFO_RD_DATA) ^ PAR_TYP;
        end
    end

    // Line and busy are registered from the upcoming state so they change on the bit edge.
    always_comb begin
        tx_next   = 1'b1;
        busy_next = 1'b1;
        case (state_next)
            IDLE:    busy_next = 1'b0;
            START:   tx_next   = 1'b0;
            DATA:    tx_next   = shift_next[0];
            PARITY:  tx_next   = par_bit_next;
            STOP:    tx_next   = 1'b1;
            default: busy_next = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue acts as the FIFO, each pushed word queues its expected
// frame, and a negedge monitor checks line, busy and pop strobe cycle by cycle.
module tb_fifo_uart_tx;
    localparam int DW = 8;
    localparam int PW = 6;

    typedef struct {
        logic [DW-1:0] word;
        bit            par_en;
        bit            par;
        int            p;
    } frame_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic          FIFO_EMPTY;
    logic [DW-1:0] FIFO_RD_DATA;
    logic          FIFO_RD_INC;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [PW-1:0] PRESCALE;
    logic          TX_OUT;
    logic          BUSY;

    int            vectors     = 0;
    int            miscompares = 0;
    logic [DW-1:0] fifo_q[$];
    frame_t        exp_q[$];

    bit            mon_rst     = 1'b1;
    bit            mon_in      = 1'b0;
    bit            mon_want    = 1'b0;
    int            mon_k       = 0;
    int            mon_len     = 0;
    frame_t        mon_cur;

    always #5 CLK = ~CLK;

    fifo_uart_tx #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .FIFO_EMPTY   (FIFO_EMPTY),
        .FIFO_RD_DATA (FIFO_RD_DATA),
        .FIFO_RD_INC  (FIFO_RD_INC),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .PRESCALE     (PRESCALE),
        .TX_OUT       (TX_OUT),
        .BUSY         (BUSY)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Parity bit that makes the total count of ones even (odd when odd_typ is set).
    function automatic bit parity_of(input logic [DW-1:0] w, input bit odd_typ);
        int ones;
        ones = 0;
        for (int i = 0; i < DW; i++) if (w[i]) ones++;
        return ((ones % 2) == 1) ^ odd_typ;
    endfunction

    // Line level of bit slot b of a frame: start, data LSB first, optional parity, stop.
    function automatic bit frame_bit(input frame_t f, input int b);
        if (b == 0) return 1'b0;
        if (b <= DW) return f.word[b-1];
        if (f.par_en && b == DW + 1) return f.par;
        return 1'b1;
    endfunction

    task automatic drive_fifo();
        FIFO_EMPTY   = (fifo_q.size() == 0);
        FIFO_RD_DATA = (fifo_q.size() != 0) ? fifo_q[0] : DW'($urandom);
    endtask

    task automatic set_cfg(input bit pe, input bit pt, input logic [PW-1:0] pre);
        PAR_EN   = pe;
        PAR_TYP  = pt;
        PRESCALE = pre;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        frame_t f;
        f.word   = w;
        f.par_en = PAR_EN;
        f.par    = parity_of(w, PAR_TYP);
        f.p      = (PRESCALE == 0) ? 1 : int'(PRESCALE);
        fifo_q.push_back(w);
        exp_q.push_back(f);
        drive_fifo();
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        if (FIFO_RD_INC === 1'b1) begin
            check("pop_nonempty", fifo_q.size() != 0, 1);
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        end
        drive_fifo();
    endtask

    task automatic wait_drain(input bit scramble);
        int n;
        n = 0;
        while (fifo_q.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        check("drain_fifo", fifo_q.size() == 0, 1);
        // Config changes mid-frame must not disturb the frame on the line.
        if (scramble) set_cfg(1'($urandom), 1'($urandom), PW'($urandom));
        n = 0;
        while (BUSY !== 1'b0 && n < 2000) begin
            tick();
            n++;
        end
        check("return_idle", BUSY, 0);
        repeat (2) tick();
    endtask

    initial begin : monitor
        forever begin
            @(negedge CLK);
            if (mon_rst) begin
                check("reset_outputs", {TX_OUT, BUSY, FIFO_RD_INC}, 3'b100);
                mon_in = 1'b0;
            end else begin
                if (!mon_in && mon_want) begin
                    check("frame_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        mon_cur = exp_q.pop_front();
                        mon_in  = 1'b1;
                        mon_k   = 0;
                        mon_len = (DW + 2 + (mon_cur.par_en ? 1 : 0)) * mon_cur.p;
                    end
                end
                if (mon_in) begin
                    check($sformatf("frame_%02h_cycle_%0d", mon_cur.word, mon_k),
                          {TX_OUT, BUSY, FIFO_RD_INC},
                          {frame_bit(mon_cur, mon_k / mon_cur.p), 1'b1, mon_k == 0});
                    mon_k++;
                    if (mon_k == mon_len) mon_in = 1'b0;
                end else begin
                    check("idle", {TX_OUT, BUSY, FIFO_RD_INC}, 3'b100);
                end
            end
            // Inputs seen here are exactly what the DUT samples on the next rising edge.
            mon_want = !mon_in && (FIFO_EMPTY === 1'b0) && (RST === 1'b0);
            mon_rst  = (RST !== 1'b0);
        end
    end

    initial begin : stimulus
        int nw;
        int n;
        RST = 1'b1;
        set_cfg(1'b0, 1'b0, PW'(4));
        push_word(8'hA5);
        repeat (3) tick();
        RST = 1'b0;
        wait_drain(1'b1);

        set_cfg(1'b1, 1'b0, PW'(4));
        push_word(8'hA5);
        wait_drain(1'b1);
        set_cfg(1'b1, 1'b0, PW'(4));
        push_word(8'h07);
        wait_drain(1'b1);
        set_cfg(1'b1, 1'b1, PW'(4));
        push_word(8'h07);
        wait_drain(1'b1);

        set_cfg(1'b0, 1'b0, PW'(2));
        push_word(8'h3C);
        push_word(8'hC3);
        wait_drain(1'b1);

        set_cfg(1'b0, 1'b0, PW'(0));
        push_word(8'h55);
        wait_drain(1'b1);

        set_cfg(1'b1, 1'b0, PW'(3));
        push_word(8'h96);
        push_word(8'h5A);
        n = 0;
        while (BUSY !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("start_seen", BUSY, 1);
        repeat (13) tick();
        RST = 1'b1;
        repeat (2) tick();
        RST = 1'b0;
        wait_drain(1'b1);

        for (int ph = 0; ph < 25; ph++) begin
            nw = $urandom_range(1, 4);
            set_cfg(1'($urandom), 1'($urandom), PW'($urandom_range(0, 5)));
            push_word(DW'($urandom));
            for (int w = 1; w < nw; w++) begin
                repeat ($urandom_range(0, 30)) tick();
                push_word(DW'($urandom));
            end
            wait_drain(1'b1);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
